// File: rtl/lvds_word_aligner.sv
// -----------------------------------------------------------------------------
// lvds_word_aligner
//
// Word aligner that sits behind an LVDS deserializer, in its core-clock domain.
// Raw deserialized words arrive with an unknown bit slip. The aligner slides a
// DATA_W-bit window across the last two words until the window shows the
// training pattern. It then confirms the pattern over LOCK_COUNT consecutive
// training words, freezes the offset and supervises lock during later training
// periods.
//
// Ports
//   clk             in   deserializer core clock
//   reset           in   asynchronous, active-high reset
//   rx_data         in   raw deserialized word                  [DATA_W]
//   rx_valid        in   rx_data valid this cycle (accepted word)
//   train_en        in   link currently carries TRAIN_PATTERN
//   data_out        out  aligned word, one cycle after acceptance [DATA_W]
//   data_out_valid  out  rx_valid delayed by one cycle
//   locked          out  alignment locked (registered)
//   offset          out  current bit offset                    [$clog2(DATA_W)]
//   err_cnt         out  saturating count of training mismatches while locked
// -----------------------------------------------------------------------------
module lvds_word_aligner #(
  parameter int unsigned        DATA_W        = 8,
  parameter logic [DATA_W-1:0]  TRAIN_PATTERN = 8'hF1,
  parameter int unsigned        LOCK_COUNT    = 16,
  parameter int unsigned        LOSS_COUNT    = 4,
  localparam int unsigned       OFF_W         = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              train_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              locked,
  output logic [OFF_W-1:0]  offset,
  output logic [15:0]       err_cnt
);

  // FSM encoding
  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_CONFIRM = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  localparam logic [OFF_W-1:0] OFF_MAX    = OFF_W'(DATA_W - 1);
  localparam logic [7:0]       LOCK_CNT_8 = 8'(LOCK_COUNT);
  localparam logic [7:0]       LOSS_CNT_8 = 8'(LOSS_COUNT);
  localparam logic [15:0]      ERR_MAX    = 16'hFFFF;

  // Registers
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_prev;
  logic [OFF_W-1:0]  r_offset;
  logic [7:0]        r_match_cnt;
  logic [7:0]        r_miss_cnt;
  logic [15:0]       r_err_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_out_valid;
  logic              r_locked;

  // Window and next-state wires
  logic [2*DATA_W-1:0] w_combined;
  logic [2*DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0]   w_cand;
  logic                w_match;
  logic [OFF_W-1:0]    w_offset_inc;
  logic [7:0]          w_match_cnt_inc;
  logic [7:0]          w_miss_cnt_inc;
  logic [15:0]         w_err_cnt_sat;

  logic [1:0]          w_state_nxt;
  logic [OFF_W-1:0]    w_offset_nxt;
  logic [7:0]          w_match_cnt_nxt;
  logic [7:0]          w_miss_cnt_nxt;
  logic [15:0]         w_err_cnt_nxt;

  // The current word sits above the previous one, so a right shift by the
  // offset pulls bits from the older word into the bottom of the window. For a
  // constant input stream this is a rotate-right by the offset.
  assign w_combined = {rx_data, r_prev};
  assign w_shifted  = w_combined >> r_offset;
  assign w_cand     = w_shifted[DATA_W-1:0];
  assign w_match    = (w_cand == TRAIN_PATTERN);

  // Offset walks 0..DATA_W-1 and wraps, which also covers non-power-of-two
  // word widths where the counter has spare codes.
  assign w_offset_inc    = (r_offset == OFF_MAX) ? '0 : r_offset + OFF_W'(1);
  assign w_match_cnt_inc = r_match_cnt + 8'd1;
  assign w_miss_cnt_inc  = r_miss_cnt + 8'd1;
  assign w_err_cnt_sat   = (r_err_cnt == ERR_MAX) ? r_err_cnt : r_err_cnt + 16'd1;

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement leaves a signal unassigned and no latch forms.
  always_comb begin
    w_state_nxt     = r_state;
    w_offset_nxt    = r_offset;
    w_match_cnt_nxt = r_match_cnt;
    w_miss_cnt_nxt  = r_miss_cnt;
    w_err_cnt_nxt   = r_err_cnt;

    // Only accepted training words move the FSM; payload words and idle
    // cycles leave every counter untouched.
    if (rx_valid && train_en) begin
      case (r_state)
        S_SEARCH: begin
          if (w_match) begin
            w_match_cnt_nxt = 8'd1;
            w_state_nxt     = (LOCK_CNT_8 == 8'd1) ? S_LOCKED : S_CONFIRM;
          end else begin
            w_offset_nxt = w_offset_inc;
          end
        end

        S_CONFIRM: begin
          if (w_match) begin
            w_match_cnt_nxt = w_match_cnt_inc;
            // Locks on the same edge that accepts the LOCK_COUNT-th match.
            if (w_match_cnt_inc == LOCK_CNT_8) begin
              w_state_nxt = S_LOCKED;
            end
          end else begin
            w_state_nxt     = S_SEARCH;
            w_offset_nxt    = w_offset_inc;
            w_match_cnt_nxt = 8'd0;
          end
        end

        S_LOCKED: begin
          if (w_match) begin
            w_miss_cnt_nxt = 8'd0;
          end else begin
            // The deciding mismatch is still counted as an error before the
            // FSM falls back to search at the unchanged offset.
            w_err_cnt_nxt = w_err_cnt_sat;
            if (w_miss_cnt_inc == LOSS_CNT_8) begin
              w_state_nxt     = S_SEARCH;
              w_miss_cnt_nxt  = 8'd0;
              w_match_cnt_nxt = 8'd0;
            end else begin
              w_miss_cnt_nxt = w_miss_cnt_inc;
            end
          end
        end

        default: begin
          w_state_nxt     = S_SEARCH;
          w_match_cnt_nxt = 8'd0;
          w_miss_cnt_nxt  = 8'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_SEARCH;
      r_prev           <= '0;
      r_offset         <= '0;
      r_match_cnt      <= 8'd0;
      r_miss_cnt       <= 8'd0;
      r_err_cnt        <= 16'd0;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
      r_locked         <= 1'b0;
    end else begin
      r_data_out_valid <= rx_valid;
      if (rx_valid) begin
        r_prev      <= rx_data;
        r_data_out  <= w_cand;
        r_state     <= w_state_nxt;
        r_offset    <= w_offset_nxt;
        r_match_cnt <= w_match_cnt_nxt;
        r_miss_cnt  <= w_miss_cnt_nxt;
        r_err_cnt   <= w_err_cnt_nxt;
        // Registered from the next state so it tracks r_state exactly and
        // reaches the port straight from a flop.
        r_locked    <= (w_state_nxt == S_LOCKED);
      end
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign locked         = r_locked;
  assign offset         = r_offset;
  assign err_cnt        = r_err_cnt;

endmodule
